// File: rtl/zet_wb_bridge.sv
// zet_wb_bridge: turns the Zet core's flat access request into Wishbone classic
// bus cycles and stalls the core (cpu_block) until the access completes.
// A word access at an odd address becomes two byte cycles inside one
// continuous cyc/stb assertion. Read data is returned aligned to the core.
//
// Optional feature: define ZET_WB_TIMEOUT_EN to terminate an access after
// TIMEOUT clk cycles without ack. Missing read bytes become 8'hFF and bus_err
// pulses for one cycle. Without the macro the bridge waits for ack
// indefinitely and bus_err stays 0.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   cpu_adr_o     20-bit byte address (I/O uses [15:0])
//   cpu_dat_o     write data (byte writes use [7:0])
//   cpu_byte_o    1 = byte access
//   cpu_m_io      1 = I/O space
//   cpu_we_o      1 = write
//   cpu_dat_i     read data to core, valid while cpu_block = 0
//   cpu_block     stall to core
//   wb_*          Wishbone classic master (wb_tga_o = 1 for I/O cycles)
//   bus_err       one-cycle timeout pulse
module zet_wb_bridge #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [19:0] cpu_adr_o,
  input  logic [15:0] cpu_dat_o,
  input  logic        cpu_byte_o,
  input  logic        cpu_m_io,
  input  logic        cpu_we_o,
  output logic [15:0] cpu_dat_i,
  output logic        cpu_block,
  output logic [18:0] wb_adr_o,
  output logic [1:0]  wb_sel_o,
  output logic [15:0] wb_dat_o,
  input  logic [15:0] wb_dat_i,
  output logic        wb_we_o,
  output logic        wb_tga_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  input  logic        wb_ack_i,
  output logic        bus_err
);

  localparam int unsigned CNT_W = 10;

  // Reject an out-of-range ack wait limit at elaboration.
  if (TIMEOUT < 1 || TIMEOUT > 1023) begin : g_bad_timeout
    $error("zet_wb_bridge: TIMEOUT must be in 1..1023");
  end

  typedef enum logic [1:0] {IDLE, CYC1, CYC2, DONE} state_t;

  state_t      state_q, state_d;
  logic [19:0] adr_q, adr_d;
  logic [7:0]  dat_hi_q, dat_hi_d;
  logic        byte_q, byte_d;
  logic        we_q, we_d;
  logic        mio_q, mio_d;
  logic        split_q, split_d;
  logic [15:0] result_q, result_d;

  logic [18:0] wb_adr_d;
  logic [1:0]  wb_sel_d;
  logic [15:0] wb_dat_d;
  logic        wb_we_d, wb_tga_d, wb_cyc_d, wb_stb_d;
  logic        bus_err_d;
  logic        cpu_block_d;
  logic [15:0] cpu_dat_d;

  logic [7:0]  lane;
  logic [18:0] next_adr;

`ifdef ZET_WB_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             expired;
  assign expired = (cnt_q == CNT_W'(TIMEOUT - 1));
`endif

  // Byte lane holding the CYC1 read data.
  assign lane = adr_q[0] ? wb_dat_i[15:8] : wb_dat_i[7:0];

  // Second-cycle word address; I/O space wraps within 16 bits.
  assign next_adr = mio_q ? {4'h0, 15'(adr_q[15:1] + 15'd1)}
                          : 19'(adr_q[19:1] + 19'd1);

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      adr_q     <= '0;
      dat_hi_q  <= '0;
      byte_q    <= 1'b0;
      we_q      <= 1'b0;
      mio_q     <= 1'b0;
      split_q   <= 1'b0;
      result_q  <= '0;
      wb_adr_o  <= '0;
      wb_sel_o  <= '0;
      wb_dat_o  <= '0;
      wb_we_o   <= 1'b0;
      wb_tga_o  <= 1'b0;
      wb_cyc_o  <= 1'b0;
      wb_stb_o  <= 1'b0;
      bus_err   <= 1'b0;
      cpu_block <= 1'b1;
      cpu_dat_i <= '0;
`ifdef ZET_WB_TIMEOUT_EN
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      adr_q     <= adr_d;
      dat_hi_q  <= dat_hi_d;
      byte_q    <= byte_d;
      we_q      <= we_d;
      mio_q     <= mio_d;
      split_q   <= split_d;
      result_q  <= result_d;
      wb_adr_o  <= wb_adr_d;
      wb_sel_o  <= wb_sel_d;
      wb_dat_o  <= wb_dat_d;
      wb_we_o   <= wb_we_d;
      wb_tga_o  <= wb_tga_d;
      wb_cyc_o  <= wb_cyc_d;
      wb_stb_o  <= wb_stb_d;
      bus_err   <= bus_err_d;
      cpu_block <= cpu_block_d;
      cpu_dat_i <= cpu_dat_d;
`ifdef ZET_WB_TIMEOUT_EN
      cnt_q     <= cnt_d;
`endif
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    adr_d       = adr_q;
    dat_hi_d    = dat_hi_q;
    byte_d      = byte_q;
    we_d        = we_q;
    mio_d       = mio_q;
    split_d     = split_q;
    result_d    = result_q;
    wb_adr_d    = wb_adr_o;
    wb_sel_d    = wb_sel_o;
    wb_dat_d    = wb_dat_o;
    wb_we_d     = wb_we_o;
    wb_tga_d    = wb_tga_o;
    wb_cyc_d    = wb_cyc_o;
    wb_stb_d    = wb_stb_o;
    bus_err_d   = 1'b0;
    cpu_block_d = 1'b1;
    cpu_dat_d   = cpu_dat_i;
`ifdef ZET_WB_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif

    case (state_q)
      IDLE: begin
        // Capture the request and launch the first bus cycle.
        adr_d    = cpu_adr_o;
        dat_hi_d = cpu_dat_o[15:8];
        byte_d   = cpu_byte_o;
        we_d     = cpu_we_o;
        mio_d    = cpu_m_io;
        split_d  = !cpu_byte_o && cpu_adr_o[0];
        result_d = '0;
        wb_adr_d = cpu_adr_o[19:1];
        wb_we_d  = cpu_we_o;
        wb_tga_d = cpu_m_io;
        wb_cyc_d = 1'b1;
        wb_stb_d = 1'b1;
        if (!cpu_byte_o && !cpu_adr_o[0]) begin
          wb_sel_d = 2'b11;
          wb_dat_d = cpu_dat_o;
        end else if (!cpu_adr_o[0]) begin
          wb_sel_d = 2'b01;
          wb_dat_d = {8'h00, cpu_dat_o[7:0]};
        end else begin
          wb_sel_d = 2'b10;
          wb_dat_d = {cpu_dat_o[7:0], 8'h00};
        end
`ifdef ZET_WB_TIMEOUT_EN
        cnt_d = '0;
`endif
        state_d = CYC1;
      end

      CYC1: begin
        if (wb_ack_i) begin
          if (split_q) begin
            // Move to the high byte without releasing cyc/stb.
            result_d[7:0] = lane;
            wb_adr_d      = next_adr;
            wb_sel_d      = 2'b01;
            wb_dat_d      = {8'h00, dat_hi_q};
`ifdef ZET_WB_TIMEOUT_EN
            cnt_d = '0;
`endif
            state_d = CYC2;
          end else begin
            result_d = byte_q ? {8'h00, lane} : wb_dat_i;
            wb_cyc_d = 1'b0;
            wb_stb_d = 1'b0;
            state_d  = DONE;
          end
        end
`ifdef ZET_WB_TIMEOUT_EN
        else if (expired) begin
          result_d  = byte_q ? 16'h00FF : 16'hFFFF;
          wb_cyc_d  = 1'b0;
          wb_stb_d  = 1'b0;
          bus_err_d = 1'b1;
          state_d   = DONE;
        end else begin
          cnt_d = CNT_W'(cnt_q + CNT_W'(1));
        end
`endif
      end

      CYC2: begin
        if (wb_ack_i) begin
          result_d[15:8] = wb_dat_i[7:0];
          wb_cyc_d       = 1'b0;
          wb_stb_d       = 1'b0;
          state_d        = DONE;
        end
`ifdef ZET_WB_TIMEOUT_EN
        else if (expired) begin
          result_d[15:8] = 8'hFF;
          wb_cyc_d       = 1'b0;
          wb_stb_d       = 1'b0;
          bus_err_d      = 1'b1;
          state_d        = DONE;
        end else begin
          cnt_d = CNT_W'(cnt_q + CNT_W'(1));
        end
`endif
      end

      DONE: state_d = IDLE;

      default: state_d = IDLE;
    endcase

    // Release the core for the single DONE cycle; writes return zero.
    if (state_d == DONE) begin
      cpu_block_d = 1'b0;
      cpu_dat_d   = we_q ? 16'h0000 : result_d;
    end
  end

endmodule

// File: doc/zet_wb_bridge.md
Name: zet_wb_bridge

Overview:
Downstream neighbour of the Zet processor core. Converts the core's flat access request (address, byte flag, write enable, memory/I/O select, write data) into Wishbone classic bus cycles, and stalls the core via cpu_block until each access completes. Word accesses at odd addresses are split into two byte cycles inside one locked bus cycle. Read data is returned aligned to the core.

Parameters:
TIMEOUT, 255, ack wait limit in clk cycles; used only when ZET_WB_TIMEOUT_EN is defined; legal range 1..1023.

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
cpu_adr_o  in  20  byte address from the core; for I/O only bits [15:0] are used
cpu_dat_o  in  16  write data from the core; a byte write uses bits [7:0]
cpu_byte_o  in  1  1 = byte access, 0 = word access
cpu_m_io  in  1  1 = I/O space, 0 = memory space
cpu_we_o  in  1  1 = write
cpu_dat_i  out  16  read data to the core; valid while cpu_block=0
cpu_block  out  1  stall to the core
wb_adr_o  out  19  word address [19:1]
wb_sel_o  out  2  byte lane selects
wb_dat_o  out  16  write data
wb_dat_i  in  16  read data
wb_we_o  out  1  write enable
wb_tga_o  out  1  1 = I/O cycle
wb_cyc_o  out  1  cycle
wb_stb_o  out  1  strobe
wb_ack_i  in  1  acknowledge
bus_err  out  1  one-cycle timeout pulse; tied 0 when the optional feature is compiled out

Behaviour:
- FSM states: IDLE, CYC1, CYC2, DONE. On reset: state=IDLE; wb_cyc_o, wb_stb_o, wb_we_o, wb_tga_o and bus_err = 0; wb_sel_o=0; wb_adr_o=0; wb_dat_o=0; cpu_dat_i=0; cpu_block=1.
- cpu_block = (state != DONE), registered-state decode. The core holds its request stable while blocked.
- IDLE: latch adr, dat, byte, we and m_io. Compute split = !byte & adr[0]. Next state is CYC1. On entering CYC1, assert cyc and stb.
- CYC1 lane mapping:
  - Word, even address: sel=11, wb_dat_o=dat.
  - Byte, even address: sel=01, wb_dat_o[7:0]=dat[7:0].
  - Byte, odd address: sel=10, wb_dat_o[15:8]=dat[7:0].
  - Split (word, odd address): sel=10, wb_dat_o[15:8]=dat[7:0].
- CYC1 wb_adr_o = adr[19:1]. wb_tga_o = m_io; wb_we_o = we.
- Ack in CYC1:
  - Capture the lane read data into result[7:0]. For a non-split access, result = word data, or {8'h00, byte lane}.
  - If split, go to CYC2; otherwise drop cyc/stb and go to DONE.
- CYC2: cyc and stb stay high continuously with no gap. wb_adr_o = (adr[19:1]+1), with wrap: 20-bit wrap for memory; for I/O, 16-bit wrap with bits [19:16]=0. sel=01, wb_dat_o[7:0]=dat[15:8]. On ack: result[15:8]=wb_dat_i[7:0], drop cyc/stb, go to DONE.
- DONE: lasts exactly 1 cycle. cpu_dat_i = result; cpu_block = 0. Next state is IDLE.
- Latency with zero-wait ack: aligned access = 3 clk; split access = 4 clk. Each wait state adds 1 clk.
- wb_ack_i is ignored in IDLE and DONE.
- rst mid-cycle: cyc/stb drop at that edge; a late ack is ignored.
- Write cycles return cpu_dat_i = 0.

Optional Feature:
ZET_WB_TIMEOUT_EN.
- Defined: a 10-bit counter clears on entry to CYC1/CYC2 and increments each waiting cycle. When it reaches TIMEOUT without ack:
  - Terminate the access: drop cyc/stb.
  - Substitute 8'hFF for each missing read byte.
  - Pulse bus_err for one cycle.
  - Go to DONE; a split access skips CYC2.
- Undefined: no counter; the bridge waits for ack indefinitely; bus_err = 0.

Test Plan:
- Read word, memory adr=20'h12344, ack after 2 waits, wb_dat_i=16'hBEEF -> wb_adr_o=19'h091A2, sel=11, tga=0; cpu_dat_i=16'hBEEF in DONE; cpu_block low exactly 1 cycle.
- Write byte adr=20'h00101, dat=16'h0055 -> sel=10, wb_dat_o[15:8]=8'h55, we=1; single ack -> DONE.
- Read word adr=20'h00203, first ack data 16'hAA00, second ack data 16'h00BB -> CYC1 adr=19'h00101 sel=10, CYC2 adr=19'h00102 sel=01, cyc held high throughout; cpu_dat_i=16'hBBAA.
- Write word adr=20'hFFFFF, memory, dat=16'h1234 -> CYC1 adr=19'h7FFFF sel=10 data[15:8]=34; CYC2 adr=19'h00000 sel=01 data[7:0]=12. Repeat as I/O at port 16'hFFFF -> CYC2 adr=19'h00000, tga=1.
- Assert rst while in CYC1 awaiting ack, then ack one cycle after reset -> cyc/stb=0 after the reset edge; state IDLE; cpu_block=1; the ack has no effect.
- ZET_WB_TIMEOUT_EN with TIMEOUT=4, read word, no ack -> bus_err pulse; cpu_dat_i=16'hFFFF; return to IDLE. Without the macro, the bridge is still blocked after 1000 cycles.
